sram_wo_ctrl: RTL
=================

# sram_wo_ctrl

Write-once SRAM controller and two-port arbiter placed in front of the single-port 64-bit scratch SRAM. After reset it zero-fills the array, then shares the SRAM between two requesters with round-robin arbitration. It enforces per-word write-once semantics through an internal lock bitmap: a word accepts one effective write, and every later write to that word is rejected with an error. A privileged clear input rearms all words.

## Interface

Parameters:
- DATA_WIDTH, 64, word width; be is bit-granular.
- NUM_WORDS, 1024, depth; must be a power of two.
- ADDR_WIDTH, $clog2(NUM_WORDS), derived; not overridden.

Ports (r = requester index 0/1, one set per requester):
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- lock_clear_i  in  1  one-cycle pulse; clears entire lock bitmap.
- init_done_o  out  1  high once zero-fill complete.
- rq_req_i[r]  in  1  request valid.
- rq_we_i[r]  in  1  1 = write, 0 = read.
- rq_addr_i[r]  in  ADDR_WIDTH  word address.
- rq_wdata_i[r]  in  DATA_WIDTH  write data.
- rq_be_i[r]  in  DATA_WIDTH  per-bit write enable.
- rq_gnt_o[r]  out  1  request accepted this cycle (combinational).
- rq_rvalid_o[r]  out  1  response valid, one pulse per accepted request.
- rq_rdata_o[r]  out  DATA_WIDTH  read data; 0 when rvalid low or for writes.
- rq_err_o[r]  out  1  write rejected; qualified by rvalid.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_be_o  out  DATA_WIDTH  SRAM bit enables.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data; valid the cycle after a read request.

## Operation

- **States:** INIT, RUN.
- **Reset:** rst_i forces INIT, init counter 0, lock bitmap all 0, RR pointer 0, and pipeline valids 0. While rst_i is high, all outputs are 0.
- **INIT:** each cycle drives sram_req_o=1, we=1, addr=counter, wdata=0, be=all ones, then increments the counter.
  - All gnt_o are 0 and lock_clear_i is ignored.
  - After address NUM_WORDS-1 is written, the state moves to RUN.
- **RUN, arbitration:**
  - Only one requester active: it is granted.
  - Both active: the requester indexed by the RR pointer is granted.
  - After any grant made while both were requesting, the pointer moves to the non-granted index. Otherwise the pointer is unchanged.
  - At most one grant per cycle.
- **Accepted read:** issued to the SRAM as a read.
- **Accepted write:** rejected when lock[addr]==1, or when the address matches the pending stage-1 write. A rejected write is not issued to the SRAM and its response carries err=1.
- **be==0 write:** acts as a no-op. It is not issued, lock is not set, and err=0.
- **Otherwise:** the write is issued, and lock[addr] is set at the acceptance edge.
- **Lock set rule:** a write is locked regardless of how many be bits are set. Partial writes lock the whole word.
- **lock_clear_i:** clears all lock bits at the edge. If it coincides with an accepted write, the clear is applied first and that write's lock bit is then set, so the word ends locked. A pending stage-1 write still completes.
- **Ordering:** responses return per requester in acceptance order; the pipeline never stalls.

## Timing

- **Cycle t:** rq_gnt_o[r]=1 combinationally with rq_req_i.
- **Cycle t+1:** registered SRAM command on sram_* (stage 1). sram_req_o=0 when rejected, a no-op, or idle.
- **Cycle t+2:** rq_rvalid_o[r]=1 for one cycle.
  - Reads: rq_rdata_o = sram_rdata_i.
  - Writes: rdata 0 and err as decided at t.
- **Throughput:** one request per cycle, with back-to-back grants to alternating or the same requester.
- **Read-after-write:** a read accepted at t+1 to a word written at t returns the new data.
- **INIT duration:** exactly NUM_WORDS cycles. With rst_i low from cycle 0, the first gnt is possible and init_done_o=1 at cycle NUM_WORDS.
- **Reset mid-operation:** in-flight responses are dropped (no rvalid), and zero-fill restarts from address 0.

## Test plan

1. **Zero-fill:** release reset, wait for init_done_o (asserted at cycle 1024), then read addr 5 on port 0. Required: rvalid at t+2 with rdata=0 and err=0.
2. **Write-once:** port 0 writes 0xA5A5 to addr 7 with be=all ones, then writes 0xFFFF to addr 7, then reads addr 7. Required responses: err=0, then err=1 with no SRAM write issued, then rdata=0xA5A5.
3. **Arbitration:** both ports request reads every cycle for 6 cycles. Required: grants alternate 0,1,0,1,0,1 and each port gets 3 rvalids in order.
4. **Clear collision:** lock addr 3 and addr 9. In one cycle, pulse lock_clear_i while port 1 writes addr 4. Required:
   - A subsequent write to addr 3 gives err=0.
   - A write to addr 4 gives err=1.
5. **Edge writes:**
   - be=0 write to addr 12 gives err=0 and no lock; a later full write to addr 12 gives err=0.
   - A partial be=0x1 write then locks addr 20 against a further write.
6. **Reset mid-run:** assert rst_i one cycle after a read grant. Required: no rvalid, gnt=0 for 1024 cycles, and the data at a previously written address reads 0.

Source files
------------

// File: rtl/sram_wo_ctrl.sv
`timescale 1ns/1ps
// Write-once SRAM controller with a two-requester round-robin arbiter.
// After reset the array is zero-filled, then requests are accepted one per
// cycle. A per-word lock bitmap rejects every write after the first
// effective one, until lock_clear_i rearms all words.
module sram_wo_ctrl #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_WORDS  = 1024,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             lock_clear_i,
   output logic                             init_done_o,
   input  logic [1:0]                       rq_req_i,
   input  logic [1:0]                       rq_we_i,
   input  logic [1:0][ADDR_WIDTH-1:0]       rq_addr_i,
   input  logic [1:0][DATA_WIDTH-1:0]       rq_wdata_i,
   input  logic [1:0][DATA_WIDTH-1:0]       rq_be_i,
   output logic [1:0]                       rq_gnt_o,
   output logic [1:0]                       rq_rvalid_o,
   output logic [1:0][DATA_WIDTH-1:0]       rq_rdata_o,
   output logic [1:0]                       rq_err_o,
   output logic                             sram_req_o,
   output logic                             sram_we_o,
   output logic [ADDR_WIDTH-1:0]            sram_addr_o,
   output logic [DATA_WIDTH-1:0]            sram_wdata_o,
   output logic [DATA_WIDTH-1:0]            sram_be_o,
   input  logic [DATA_WIDTH-1:0]            sram_rdata_i
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
   logic [NUM_WORDS-1:0]    lock_q, lock_d;
   logic                    rr_q, rr_d;

   // Stage 1: registered SRAM command plus response bookkeeping.
   logic                    s1_valid_q, s1_port_q, s1_err_q, s1_rd_q, s1_issue_q, s1_we_q;
   logic [ADDR_WIDTH-1:0]   s1_addr_q;
   logic [DATA_WIDTH-1:0]   s1_wdata_q, s1_be_q;

   // Stage 2: response presented to the requester.
   logic                    s2_valid_q, s2_port_q, s2_err_q, s2_rd_q;

   logic                    sel, accept, lock_hit, be_zero, wr_err, issue;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata, sel_be;
   logic [1:0]              gnt;

   assign sel_we    = rq_we_i[sel];
   assign sel_addr  = rq_addr_i[sel];
   assign sel_wdata = rq_wdata_i[sel];
   assign sel_be    = rq_be_i[sel];
   assign accept    = |gnt;
   assign be_zero   = (sel_be == '0);
   // The stage-1 compare covers a write still in flight to the same word.
   assign lock_hit  = lock_q[sel_addr] || (s1_issue_q && s1_we_q && (s1_addr_q == sel_addr));
   assign wr_err    = accept && sel_we && !be_zero && lock_hit;
   assign issue     = accept && !(sel_we && (be_zero || lock_hit));

   // Round-robin arbitration; pointer only moves when both requesters compete.
   always_comb begin
      sel  = 1'b0;
      gnt  = '0;
      rr_d = rr_q;
      if (!rst_i && state_q == StRun) begin
         if (&rq_req_i) begin
            sel  = rr_q;
            rr_d = ~rr_q;
         end else if (rq_req_i[1]) begin
            sel = 1'b1;
         end
         gnt[sel] = |rq_req_i;
      end
   end

   // Init sweep counter and INIT -> RUN transition.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == StInit) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
            state_d = StRun;
         end
      end
   end

   // Lock bitmap next state: clear first, then the accepted write locks its word.
   always_comb begin
      lock_d = lock_q;
      if (state_q == StRun && lock_clear_i) begin
         lock_d = '0;
      end
      if (issue && sel_we) begin
         lock_d[sel_addr] = 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         lock_q     <= '0;
         rr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         lock_q     <= lock_d;
         rr_q       <= rr_d;
      end
   end

   // Two-stage request pipeline; it never stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_port_q  <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_rd_q    <= 1'b0;
         s1_issue_q <= 1'b0;
         s1_we_q    <= 1'b0;
         s1_addr_q  <= '0;
         s1_wdata_q <= '0;
         s1_be_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_port_q  <= 1'b0;
         s2_err_q   <= 1'b0;
         s2_rd_q    <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_port_q  <= sel;
         s1_err_q   <= wr_err;
         s1_rd_q    <= accept && !sel_we;
         s1_issue_q <= issue;
         s1_we_q    <= sel_we;
         s1_addr_q  <= sel_addr;
         s1_wdata_q <= sel_wdata;
         s1_be_q    <= sel_be;
         s2_valid_q <= s1_valid_q;
         s2_port_q  <= s1_port_q;
         s2_err_q   <= s1_err_q;
         s2_rd_q    <= s1_rd_q;
      end
   end

   // Output drive; everything is held at zero while reset is asserted.
   always_comb begin
      rq_gnt_o     = gnt;
      rq_rvalid_o  = '0;
      rq_rdata_o   = '0;
      rq_err_o     = '0;
      init_done_o  = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      if (!rst_i) begin
         if (state_q == StInit) begin
            sram_req_o  = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = init_cnt_q;
            sram_be_o   = '1;
         end else begin
            init_done_o = 1'b1;
            if (s1_issue_q) begin
               sram_req_o   = 1'b1;
               sram_we_o    = s1_we_q;
               sram_addr_o  = s1_addr_q;
               sram_wdata_o = s1_wdata_q;
               sram_be_o    = s1_be_q;
            end
         end
         rq_rvalid_o[s2_port_q] = s2_valid_q;
         rq_err_o[s2_port_q]    = s2_valid_q && s2_err_q;
         rq_rdata_o[s2_port_q]  = (s2_valid_q && s2_rd_q) ? sram_rdata_i : '0;
      end
   end

endmodule
